// File: rtl/huffman_pkg.sv
// Shared state encoding and sizing helpers for the parametrised Huffman coder.
package huffman_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_SORT  = 3'd2,
      S_MERGE = 3'd3,
      S_TRACE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int NSYM_MIN = 2;
   localparam int NSYM_MAX = 15;

   // Node ids run 1..2*NSYM-1, so this width also indexes a 2*NSYM entry table.
   function automatic int node_id_w(input int nsym);
      return $clog2(2 * nsym);
   endfunction

   function automatic int root_id(input int nsym);
      return 2 * nsym - 1;
   endfunction

   function automatic int sum_w(input int nsym, input int cnt_w);
      return cnt_w + $clog2(nsym);
   endfunction

endpackage

// File: rtl/huffman_hist.sv
// Per-symbol saturating histogram with range check and frame clear.
module huffman_hist
   import huffman_pkg::*;
#(
   parameter int NSYM   = 6,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clear,
   input  logic                  i_en,
   input  logic [DATA_W-1:0]     i_data,
   output logic [NSYM*CNT_W-1:0] o_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] r_cnt [NSYM];
   logic [NSYM-1:0]  w_hit;

   always_comb begin
      for (int s = 0; s < NSYM; s++) begin
         w_hit[s] = i_en && (i_data == DATA_W'(s + 1));
         o_cnt[s*CNT_W +: CNT_W] = r_cnt[s];
      end
   end

   // A clear cycle restarts the frame and still counts its own symbol.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NSYM; s++) r_cnt[s] <= '0;
      end else begin
         for (int s = 0; s < NSYM; s++) begin
            if (i_clear)
               r_cnt[s] <= w_hit[s] ? CNT_W'(1) : CNT_W'(0);
            else if (w_hit[s] && (r_cnt[s] != CNT_MAX))
               r_cnt[s] <= r_cnt[s] + CNT_W'(1);
            else
               r_cnt[s] <= r_cnt[s];
         end
      end
   end

endmodule

// File: rtl/huffman_param.sv
// Histogram a symbol frame, build a Huffman tree over NSYM symbols and
// emit per-symbol code (leaf bit at LSB) and length mask.
module huffman_param
   import huffman_pkg::*;
#(
   parameter int NSYM   = 6,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8,
   parameter int CODE_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   gray_valid,
   input  logic [DATA_W-1:0]      gray_data,
   output logic                   CNT_valid,
   output logic [NSYM*CNT_W-1:0]  CNT,
   output logic                   code_valid,
   output logic [NSYM*CODE_W-1:0] HC,
   output logic [NSYM*CODE_W-1:0] M
);

   localparam int IDW = node_id_w(NSYM);
   localparam int SW  = sum_w(NSYM, CNT_W);
   localparam int CW  = $clog2(NSYM + 1);
   localparam logic [IDW-1:0] ROOT_ID = IDW'(root_id(NSYM));

   if (CODE_W < NSYM - 1) begin : g_code_w_chk
      $error("huffman_param: CODE_W must be >= NSYM-1");
   end
   if (NSYM < NSYM_MIN || NSYM > NSYM_MAX) begin : g_nsym_chk
      $error("huffman_param: NSYM out of range");
   end

   state_t r_state, w_next;
   logic [IDW-1:0]    r_id  [NSYM];
   logic [SW-1:0]     r_wt  [NSYM];
   logic [IDW-1:0]    w_sid [NSYM];
   logic [SW-1:0]     w_swt [NSYM];
   logic [IDW-1:0]    r_par [2*NSYM];
   logic              r_bit [2*NSYM];
   logic [IDW-1:0]    r_cur [NSYM];
   logic [CODE_W-1:0] r_code [NSYM], r_mask [NSYM], r_hc [NSYM], r_m [NSYM];
   logic [CW-1:0]     r_len, r_pass, r_step;
   logic [IDW-1:0]    r_new_id;
   logic              r_cnt_valid, r_code_valid;
   logic [IDW-1:0]    w_c1_id, w_c0_id;
   logic [SW-1:0]     w_c1_wt, w_c0_wt, w_sum;
   logic              w_hist_en, w_hist_clr;

   function automatic logic ranks_above(input logic [SW-1:0] wa, input logic [IDW-1:0] ida,
                                        input logic [SW-1:0] wb, input logic [IDW-1:0] idb);
      return (wa > wb) || ((wa == wb) && (ida < idb));
   endfunction

   assign w_hist_en  = gray_valid && (r_state == S_IDLE || r_state == S_COUNT || r_state == S_DONE);
   assign w_hist_clr = gray_valid && (r_state == S_IDLE || r_state == S_DONE);

   huffman_hist #(.NSYM(NSYM), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_hist (
      .clk     (clk),
      .rst     (reset),
      .i_clear (w_hist_clr),
      .i_en    (w_hist_en),
      .i_data  (gray_data),
      .o_cnt   (CNT)
   );

   // One odd-even transposition pass per SORT cycle; r_len passes fully sort the list.
   always_comb begin
      for (int i = 0; i < NSYM; i++) begin
         w_sid[i] = r_id[i];
         w_swt[i] = r_wt[i];
      end
      for (int i = 0; i < NSYM - 1; i++) begin
         if ((1'(i) == r_pass[0]) && (CW'(i + 1) < r_len) &&
             ranks_above(r_wt[i+1], r_id[i+1], r_wt[i], r_id[i])) begin
            w_sid[i]   = r_id[i+1];
            w_swt[i]   = r_wt[i+1];
            w_sid[i+1] = r_id[i];
            w_swt[i+1] = r_wt[i];
         end else begin
            w_sid[i] = w_sid[i];
         end
      end
   end

   always_comb begin
      w_c1_id = '0;
      w_c1_wt = '0;
      w_c0_id = '0;
      w_c0_wt = '0;
      for (int i = 0; i < NSYM; i++) begin
         if (CW'(i) == r_len - CW'(1)) begin
            w_c1_id = r_id[i];
            w_c1_wt = r_wt[i];
         end else if (CW'(i) == r_len - CW'(2)) begin
            w_c0_id = r_id[i];
            w_c0_wt = r_wt[i];
         end else begin
            w_c1_id = w_c1_id;
         end
      end
      w_sum = w_c1_wt + w_c0_wt;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (gray_valid) w_next = S_COUNT; else w_next = S_IDLE;
         S_COUNT: if (!gray_valid) w_next = S_SORT; else w_next = S_COUNT;
         S_SORT:  if (r_pass == r_len - CW'(1)) w_next = S_MERGE; else w_next = S_SORT;
         S_MERGE: if (r_len == CW'(2)) w_next = S_TRACE; else w_next = S_SORT;
         S_TRACE: if (r_step == CW'(NSYM - 1)) w_next = S_DONE; else w_next = S_TRACE;
         S_DONE:  if (gray_valid) w_next = S_COUNT; else w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: list init, sort passes, merges, and the parallel leaf-to-root walk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_pass       <= '0;
         r_step       <= '0;
         r_new_id     <= '0;
         r_cnt_valid  <= 1'b0;
         r_code_valid <= 1'b0;
         for (int i = 0; i < NSYM; i++) begin
            r_id[i]   <= '0;
            r_wt[i]   <= '0;
            r_cur[i]  <= '0;
            r_code[i] <= '0;
            r_mask[i] <= '0;
            r_hc[i]   <= '0;
            r_m[i]    <= '0;
         end
         for (int n = 0; n < 2 * NSYM; n++) begin
            r_par[n] <= '0;
            r_bit[n] <= 1'b0;
         end
      end else begin
         r_state     <= w_next;
         r_cnt_valid <= (r_state == S_COUNT) && !gray_valid;
         case (r_state)
            S_COUNT: begin
               if (!gray_valid) begin
                  for (int i = 0; i < NSYM; i++) begin
                     r_id[i] <= IDW'(i + 1);
                     r_wt[i] <= SW'(CNT[i*CNT_W +: CNT_W]);
                  end
                  r_len    <= CW'(NSYM);
                  r_pass   <= '0;
                  r_new_id <= IDW'(NSYM + 1);
               end
            end
            S_SORT: begin
               for (int i = 0; i < NSYM; i++) begin
                  r_id[i] <= w_sid[i];
                  r_wt[i] <= w_swt[i];
               end
               r_pass <= r_pass + CW'(1);
            end
            S_MERGE: begin
               r_par[w_c1_id] <= r_new_id;
               r_bit[w_c1_id] <= 1'b1;
               r_par[w_c0_id] <= r_new_id;
               r_bit[w_c0_id] <= 1'b0;
               for (int i = 0; i < NSYM; i++) begin
                  if (CW'(i) == r_len - CW'(2)) begin
                     r_id[i] <= r_new_id;
                     r_wt[i] <= w_sum;
                  end
               end
               r_len    <= r_len - CW'(1);
               r_pass   <= '0;
               r_new_id <= r_new_id + IDW'(1);
               for (int s = 0; s < NSYM; s++) begin
                  r_cur[s]  <= IDW'(s + 1);
                  r_code[s] <= '0;
                  r_mask[s] <= '0;
               end
               r_step <= '0;
            end
            S_TRACE: begin
               if (r_step == CW'(NSYM - 1)) begin
                  for (int s = 0; s < NSYM; s++) begin
                     r_hc[s] <= r_code[s];
                     r_m[s]  <= r_mask[s];
                  end
                  r_code_valid <= 1'b1;
               end else begin
                  for (int s = 0; s < NSYM; s++) begin
                     if (r_cur[s] != ROOT_ID) begin
                        r_code[s] <= r_code[s] | (CODE_W'(r_bit[r_cur[s]]) << r_step);
                        r_mask[s] <= r_mask[s] | (CODE_W'(1) << r_step);
                        r_cur[s]  <= r_par[r_cur[s]];
                     end
                  end
                  r_step <= r_step + CW'(1);
               end
            end
            S_DONE: begin
               if (gray_valid) r_code_valid <= 1'b0;
            end
            default: begin
               r_pass <= r_pass;
            end
         endcase
      end
   end

   always_comb begin
      for (int s = 0; s < NSYM; s++) begin
         HC[s*CODE_W +: CODE_W] = r_hc[s];
         M[s*CODE_W +: CODE_W]  = r_m[s];
      end
   end

   assign CNT_valid  = r_cnt_valid;
   assign code_valid = r_code_valid;

endmodule
